// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for VGA pong: title/serve/play/game-over flow,
// frame-based timers, BCD score and lives. All outputs are registered.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 120,
  parameter int OVER_FRAMES  = 180,
  parameter int TW           = 8
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn_start,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_hold,
  output logic [1:0] game_state,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    SERVE   = 2'd1,
    PLAY    = 2'd2,
    OVER    = 2'd3
  } state_t;

  // refr_tick, hit and miss are single-cycle pulses sampled on the rising
  // edge; there is no back-pressure, every pulse is consumed or ignored.
  state_t        state;
  logic [TW-1:0] timer;
  logic          btn_start_q;
  logic          start_re;

  assign start_re   = btn_start & ~btn_start_q;
  assign game_state = state;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state       <= NEWGAME;
      timer       <= '0;
      score_tens  <= 4'd0;
      score_ones  <= 4'd0;
      lives       <= 2'(LIVES);
      ball_hold   <= 1'b1;
      game_over   <= 1'b0;
      // Held high so a button pressed through reset needs a fresh press.
      btn_start_q <= 1'b1;
    end else begin
      btn_start_q <= btn_start;
      case (state)
        NEWGAME: begin
          if (start_re) begin
            state      <= SERVE;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            lives      <= 2'(LIVES);
            timer      <= '0;
            ball_hold  <= 1'b1;
          end
        end
        SERVE: begin
          if (refr_tick) begin
            if (timer == TW'(SERVE_FRAMES - 1)) begin
              state     <= PLAY;
              timer     <= '0;
              ball_hold <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        PLAY: begin
          // A miss wins over a simultaneous hit; the hit is discarded.
          if (miss) begin
            lives     <= lives - 2'd1;
            timer     <= '0;
            ball_hold <= 1'b1;
            if (lives == 2'd1) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else if (hit) begin
            if (score_ones == 4'd9) begin
              score_ones <= 4'd0;
              score_tens <= (score_tens == 4'd9) ? 4'd0 : score_tens + 4'd1;
            end else begin
              score_ones <= score_ones + 4'd1;
            end
          end
        end
        OVER: begin
          if (refr_tick) begin
            if (timer == TW'(OVER_FRAMES - 1)) begin
              state     <= NEWGAME;
              timer     <= '0;
              game_over <= 1'b0;
              ball_hold <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          state <= NEWGAME;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed walk through the game flow
// followed by randomized play, all compared against a behavioural model.
module tb_pong_game_ctrl;

  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 120;
  localparam int OVER_FRAMES  = 180;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       refr_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       ball_hold;
  logic [1:0] game_state;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] lives;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  // Behavioural model: whole-number score and lives, phase as a name-like int.
  int m_phase;   // 0 title, 1 serve, 2 play, 3 over
  int m_frames;  // frames counted in the current phase
  int m_score;   // 0..99
  int m_lives;
  bit m_btn_prev;

  pong_game_ctrl #(
    .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .OVER_FRAMES(OVER_FRAMES), .TW(8)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .refr_tick(refr_tick),
    .btn_start(btn_start), .hit(hit), .miss(miss), .ball_hold(ball_hold),
    .game_state(game_state), .score_tens(score_tens), .score_ones(score_ones),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("state", 8'(game_state), 8'(m_phase));
    chk("tens", 8'(score_tens), 8'(m_score / 10));
    chk("ones", 8'(score_ones), 8'(m_score % 10));
    chk("lives", 8'(lives), 8'(m_lives));
    chk("ball_hold", 8'(ball_hold), 8'(m_phase != 2));
    chk("game_over", 8'(game_over), 8'(m_phase == 3));
  endtask

  task automatic model_reset();
    m_phase = 0; m_frames = 0; m_score = 0; m_lives = LIVES; m_btn_prev = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit s, input bit h, input bit m);
    bit pressed;
    pressed    = s && !m_btn_prev;
    m_btn_prev = s;
    if (m_phase == 0) begin
      if (pressed) begin
        m_phase = 1; m_frames = 0; m_score = 0; m_lives = LIVES;
      end
    end else if (m_phase == 1) begin
      if (r) begin
        m_frames++;
        if (m_frames == SERVE_FRAMES) begin m_phase = 2; m_frames = 0; end
      end
    end else if (m_phase == 2) begin
      if (m) begin
        m_lives--;
        m_frames = 0;
        m_phase = (m_lives == 0) ? 3 : 1;
      end else if (h) begin
        m_score = (m_score + 1) % 100;
      end
    end else begin
      if (r) begin
        m_frames++;
        if (m_frames == OVER_FRAMES) begin m_phase = 0; m_frames = 0; end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit h, input bit m);
    @(negedge clk_100MHz);
    reset = 1'b0; refr_tick = r; btn_start = s; hit = h; miss = m;
    model_step(r, s, h, m);
    @(posedge clk_100MHz);
    #1;
    check_model();
  endtask

  task automatic reset_cycle(input bit s, input bit h);
    @(negedge clk_100MHz);
    reset = 1'b1; refr_tick = 1'b0; btn_start = s; hit = h; miss = 1'b0;
    model_reset();
    @(posedge clk_100MHz);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n, input bit s);
    for (int i = 0; i < n; i++) cycle(1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic start_and_serve();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SERVE_FRAMES, 1'b0);
  endtask

  initial begin
    model_reset();

    // Reset with the start button held; it must not start a game.
    reset_cycle(1'b1, 1'b0);
    reset_cycle(1'b1, 1'b0);
    chk("rst_state", 8'(game_state), 8'd0);
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_hold", 8'(ball_hold), 8'd1);
    chk("rst_score", {score_tens, score_ones}, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("held_no_start", 8'(game_state), 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("press_to_serve", 8'(game_state), 8'd1);

    // Serve timing boundary.
    ticks(SERVE_FRAMES - 1, 1'b1);
    chk("serve_119", 8'(game_state), 8'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("serve_idle", 8'(game_state), 8'd1);
    ticks(1, 1'b0);
    chk("serve_120", 8'(game_state), 8'd2);
    chk("play_hold", 8'(ball_hold), 8'd0);

    // BCD scoring and wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("score_10", {score_tens, score_ones}, 8'h10);
    for (int i = 0; i < 89; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("score_99", {score_tens, score_ones}, 8'h99);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("score_wrap", {score_tens, score_ones}, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Simultaneous hit and miss: miss wins.
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hm_score", {score_tens, score_ones}, 8'h05);
    chk("hm_lives", 8'(lives), 8'd2);
    chk("hm_state", 8'(game_state), 8'd1);

    // Lose the remaining lives.
    ticks(SERVE_FRAMES, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("miss2_lives", 8'(lives), 8'd1);
    ticks(SERVE_FRAMES, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("over_state", 8'(game_state), 8'd3);
    chk("over_lives", 8'(lives), 8'd0);
    chk("over_flag", 8'(game_over), 8'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("over_ignore_start", 8'(game_state), 8'd3);
    ticks(OVER_FRAMES - 1, 1'b0);
    chk("over_179", 8'(game_state), 8'd3);
    ticks(1, 1'b0);
    chk("over_done", 8'(game_state), 8'd0);
    chk("score_kept", {score_tens, score_ones}, 8'h05);

    // Reset during play coincident with a hit.
    start_and_serve();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    reset_cycle(1'b0, 1'b1);
    chk("midrst_state", 8'(game_state), 8'd0);
    chk("midrst_score", {score_tens, score_ones}, 8'h00);
    chk("midrst_lives", 8'(lives), 8'd3);
    chk("midrst_hold", 8'(ball_hold), 8'd1);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 999) == 0) reset_cycle(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-level sequencer for the VGA pong design. It sits between the debounced buttons, the VGA frame tick and the pixel generator. It runs the title, serve, play and game-over states, counts frame-based timers, keeps the BCD score and remaining lives, and tells the pixel generator when to hold the ball at centre or let it move. All outputs are registered in the 100 MHz domain.

Parameters:
LIVES, 3, starting lives per game (1..3, fits 2-bit lives output)
SERVE_FRAMES, 120, refresh ticks the ball is held before each serve (~2 s at 60 Hz)
OVER_FRAMES, 180, refresh ticks spent in game-over before returning to title
TW, 8, width of the internal frame timer (must hold max(SERVE_FRAMES, OVER_FRAMES))

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
refr_tick  in  1  one-cycle pulse once per frame (start of vertical blank), from pixel generator
btn_start  in  1  debounced start button level
hit  in  1  one-cycle pulse: ball struck paddle
miss  in  1  one-cycle pulse: ball passed paddle
ball_hold  out  1  1 = pixel generator parks ball at centre with zero velocity
game_state  out  2  0 NEWGAME, 1 SERVE, 2 PLAY, 3 OVER (drives text overlay select)
score_tens  out  4  BCD tens digit
score_ones  out  4  BCD ones digit
lives  out  2  remaining lives
game_over  out  1  high only in OVER

Behaviour:
- Reset (sync, reset=1 at posedge) sets all of the following:
  - state NEWGAME, timer 0, score 00, lives=LIVES, ball_hold=1, game_over=0.
  - start edge-detect register set to 1, so a button held through reset does not start a game until it is released and pressed again.
- Start event: start_re = btn_start & ~btn_start_q. btn_start_q is registered every cycle.
- All transitions and output updates appear on the clock edge after the triggering input cycle (1-cycle latency). No combinational input-to-output paths.
- NEWGAME:
  - ball_hold=1. Score holds the last game's value for display.
  - start_re: go to SERVE, score to 00, lives to LIVES, timer to 0.
  - hit/miss ignored.
- SERVE:
  - ball_hold=1. Each refr_tick increments the timer.
  - On refr_tick with timer==SERVE_FRAMES-1: go to PLAY, timer to 0.
  - hit/miss and start_re ignored.
- PLAY:
  - ball_hold=0.
  - hit: BCD increment. Ones 9 wraps to 0 with a tens carry; 99 wraps to 00. Only the ones digit is ever incremented directly.
  - miss: lives decrements. If lives was 1, go to OVER with lives=0 and timer=0. Otherwise go to SERVE with timer=0.
  - hit and miss in the same cycle: miss is processed, hit is discarded (score unchanged).
  - refr_tick has no effect in PLAY.
- OVER:
  - ball_hold=1, game_over=1. Score and lives frozen.
  - Timer counts refr_ticks. On refr_tick with timer==OVER_FRAMES-1: go to NEWGAME.
  - start_re ignored in OVER.
- Timer reset: timer clears on every state entry. It never wraps, because the exit compare precedes overflow.
- Reset mid-operation: reset in any state returns to the reset condition on the next edge, regardless of pending hit/miss/tick in that cycle.
- Encoding: game_state mirrors the state register directly.

Test Plan:
- Reset held 2 cycles with btn_start=1 -> state 0, score 00, lives 3, ball_hold 1. Release then press btn_start -> state 1 one cycle after the press edge. No transition while the button stays held from reset.
- In SERVE, pulse refr_tick 119 times -> state stays 1. 120th tick -> state 2, ball_hold 0 next cycle.
- In PLAY, 10 hit pulses -> score 1,0. Preload to 99 via 99 hits, one more hit -> 0,0.
- In PLAY, pulse hit and miss in the same cycle with score 05, lives 3 -> score 05, lives 2, state 1.
- Three miss pulses across three serves -> lives 0, state 3, game_over 1. btn_start press in OVER ignored. 180 refr_ticks -> state 0, score retained.
- Assert reset during PLAY coincident with a hit pulse -> next cycle state 0, score 00, lives 3, ball_hold 1.
